nn_pcpi_coprocessor: RTL and testbench

PicoRV32 PCPI coprocessor that runs a complete two-layer fully-connected network (784→100→10) on one input image held in shared memory. It returns the predicted class index in the destination register. It attaches to the PicoRV32 PCPI port and to a dedicated single-word memory port into the system's shared word-addressed memory. Data is signed 32-bit fixed point.

---
 rtl/nn_pcpi_coprocessor.sv | 212 +++++++++++++++++++++
 tb/tb_nn_pcpi_coprocessor.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_pcpi_coprocessor.sv
// PicoRV32 PCPI coprocessor: two-layer fully-connected inference (N_IN->N_HID->N_OUT)
// over a single-word shared-memory port, returning the argmax class index in rd.
module nn_pcpi_coprocessor #(
  parameter int          FRAC_BITS = 8,
  parameter int          N_IN      = 784,
  parameter int          N_HID     = 100,
  parameter int          N_OUT     = 10,
  parameter logic [31:0] OUT_ADDR  = 32'h0020_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW-1:0] LAST_I = IW'(N_IN - 1);
  localparam logic [JW-1:0] LAST_J = JW'(N_HID - 1);
  localparam logic [KW-1:0] LAST_K = KW'(N_OUT - 1);

  typedef enum logic [2:0] {IDLE, L1_W, L1_X, L2_W, L2_ST, DONE} state_t;

  state_t             state;
  logic [IW-1:0]      i_cnt;
  logic [JW-1:0]      j_cnt;
  logic [KW-1:0]      k_cnt;
  logic signed [63:0] acc;
  logic [31:0]        w_reg;
  logic [31:0]        w_ptr;
  logic [31:0]        x_base;
  logic [31:0]        x_ptr;
  logic [31:0]        out_ptr;
  logic signed [31:0] y_reg;
  logic signed [31:0] max_val;
  logic [KW-1:0]      max_idx;
  logic [31:0]        h_buf [N_HID];

  logic               insn_match;
  logic [31:0]        mac_a;
  logic [31:0]        mac_b;
  logic signed [63:0] mac_a64;
  logic signed [63:0] mac_b64;
  logic signed [63:0] acc_next;
  logic [31:0]        acc_slice;
  logic [31:0]        relu_val;
  logic               new_best;
  logic               h_we;
  logic               unused_insn_bits;

  assign insn_match = (pcpi_insn[6:0] == 7'b0001011) && (pcpi_insn[14:12] == 3'b000) &&
                      (pcpi_insn[31:25] == 7'b0000001);
  assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
  assign pcpi_wait = resetn && pcpi_valid && insn_match && (state != DONE);

  // Weight words are contiguous (W1 then W2), so a single incrementing pointer walks both.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mac_a = '0;
    mac_b = '0;
    case (state)
      L1_X:    begin mac_a = w_reg;     mac_b = mem_rdata;    end
      L2_W:    begin mac_a = mem_rdata; mac_b = h_buf[j_cnt]; end
      default: ;
    endcase
    mac_a64   = {{32{mac_a[31]}}, mac_a};
    mac_b64   = {{32{mac_b[31]}}, mac_b};
    acc_next  = acc + mac_a64 * mac_b64;
    acc_slice = acc_next[FRAC_BITS+31:FRAC_BITS];
    relu_val  = acc_slice[31] ? 32'd0 : acc_slice;
    new_best  = (k_cnt == '0) || (y_reg > max_val);
  end

  assign h_we = resetn && (state == L1_X) && mem_ready && (i_cnt == LAST_I);

  // NOTE: the hidden buffer is plain storage with no reset; each entry is written before it is read.
  always_ff @(posedge clk) begin
    if (h_we) h_buf[j_cnt] <= relu_val;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      i_cnt      <= '0;
      j_cnt      <= '0;
      k_cnt      <= '0;
      acc        <= '0;
      w_reg      <= '0;
      w_ptr      <= '0;
      x_base     <= '0;
      x_ptr      <= '0;
      out_ptr    <= '0;
      y_reg      <= '0;
      max_val    <= '0;
      max_idx    <= '0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      pcpi_ready <= 1'b0;
      mem_valid  <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_valid <= 1'b0;
      case (state)
        IDLE: if (pcpi_valid && insn_match) begin
          i_cnt     <= '0;
          j_cnt     <= '0;
          k_cnt     <= '0;
          acc       <= '0;
          x_base    <= pcpi_rs2;
          x_ptr     <= pcpi_rs2;
          out_ptr   <= OUT_ADDR;
          w_ptr     <= pcpi_rs1 + 32'd4;
          mem_valid <= 1'b1;
          mem_write <= 1'b0;
          mem_addr  <= pcpi_rs1;
          mem_wdata <= '0;
          state     <= L1_W;
        end
        L1_W: if (mem_ready) begin
          w_reg     <= mem_rdata;
          mem_valid <= 1'b1;
          mem_addr  <= x_ptr;
          x_ptr     <= x_ptr + 32'd4;
          state     <= L1_X;
        end
        L1_X: if (mem_ready) begin
          mem_valid <= 1'b1;
          mem_addr  <= w_ptr;
          w_ptr     <= w_ptr + 32'd4;
          if (i_cnt == LAST_I) begin
            acc   <= '0;
            i_cnt <= '0;
            x_ptr <= x_base;
            if (j_cnt == LAST_J) begin
              j_cnt <= '0;
              state <= L2_W;
            end else begin
              j_cnt <= j_cnt + JW'(1);
              state <= L1_W;
            end
          end else begin
            acc   <= acc_next;
            i_cnt <= i_cnt + IW'(1);
            state <= L1_W;
          end
        end
        L2_W: if (mem_ready) begin
          mem_valid <= 1'b1;
          if (j_cnt == LAST_J) begin
            y_reg     <= acc_slice;
            acc       <= '0;
            j_cnt     <= '0;
            mem_write <= 1'b1;
            mem_addr  <= out_ptr;
            mem_wdata <= acc_slice;
            out_ptr   <= out_ptr + 32'd4;
            state     <= L2_ST;
          end else begin
            acc       <= acc_next;
            j_cnt     <= j_cnt + JW'(1);
            mem_addr  <= w_ptr;
            w_ptr     <= w_ptr + 32'd4;
          end
        end
        L2_ST: if (mem_ready) begin
          if (new_best) begin
            max_val <= y_reg;
            max_idx <= k_cnt;
          end
          if (k_cnt == LAST_K) begin
            pcpi_ready <= 1'b1;
            pcpi_wr    <= 1'b1;
            pcpi_rd    <= 32'(new_best ? k_cnt : max_idx);
            state      <= DONE;
          end else begin
            k_cnt     <= k_cnt + KW'(1);
            mem_valid <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= w_ptr;
            mem_wdata <= '0;
            w_ptr     <= w_ptr + 32'd4;
            state     <= L2_W;
          end
        end
        DONE: begin
          pcpi_ready <= 1'b0;
          pcpi_wr    <= 1'b0;
          pcpi_rd    <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_pcpi_coprocessor.sv
// Scoreboard bench for nn_pcpi_coprocessor at reduced layer sizes with a one-cycle memory model;
// logit writes and rd are popped from expectation queues by independent monitors.
module tb_nn_pcpi_coprocessor;

  localparam int          FRAC_BITS  = 8;
  localparam int          N_IN       = 16;
  localparam int          N_HID      = 12;
  localparam int          N_OUT      = 10;
  localparam logic [31:0] OUT_ADDR   = 32'h0020_0000;
  localparam logic [31:0] RS1        = 32'h0001_0000;
  localparam logic [31:0] RS2        = 32'h0002_0000;
  localparam int          N_W        = N_IN * N_HID + N_HID * N_OUT;
  localparam int          N_READS    = 2 * N_IN * N_HID + N_HID * N_OUT;
  localparam int          RUN_BUDGET = 5000;
  localparam logic [31:0] NN_INSN    = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd10, 7'b0001011};
  localparam logic [31:0] MUL_INSN   = {7'b0000001, 5'd11, 5'd10, 3'b000, 5'd10, 7'b0110011};
  localparam logic [31:0] NEAR_INSN  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd10, 7'b0001011};

  logic        clk;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  nn_pcpi_coprocessor #(
    .FRAC_BITS(FRAC_BITS), .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .OUT_ADDR(OUT_ADDR)
  ) dut (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr [$];
  logic [31:0] exp_rd [$];
  logic [31:0] mem [int unsigned];

  int errors = 0;
  int checks = 0;
  int n_rd, n_wr, n_b2b, n_oob, n_wait_gap;
  logic prev_mv = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Directed vectors: v0 identity ramp, v1 all-negative input (ReLU + tie), v2 signed logits
  // with a tie between classes 3 and 7, v3 dense rows exercising accumulation and truncation.
  function automatic int w1v(int v, int j, int i);
    if (v == 3) return 65;
    return (i == j) ? 256 : 0;
  endfunction

  function automatic int xv(int v, int i);
    case (v)
      0:       return i * 256;
      1:       return -256;
      2:       return (i == 3 || i == 7) ? 1280 : 256;
      default: return i * 256 + 1;
    endcase
  endfunction

  function automatic int w2v(int v, int k, int j);
    case (v)
      2:       return (k == j) ? ((k % 2 == 0) ? -256 : 256) : 0;
      3:       return (j <= k) ? 256 : 0;
      default: return (k == j) ? 256 : 0;
    endcase
  endfunction

  function automatic int exp_y(int v, int k);
    case (v)
      0:       return 256 * k;
      1:       return 0;
      2:       return (k % 2 == 0) ? -256 : ((k == 3 || k == 7) ? 1280 : 256);
      default: return (k + 1) * 7804;
    endcase
  endfunction

  function automatic logic [31:0] exp_class(int v);
    case (v)
      0:       return 32'd9;
      1:       return 32'd0;
      2:       return 32'd3;
      default: return 32'd9;
    endcase
  endfunction

  task automatic load_vec(input int v);
    mem.delete();
    for (int j = 0; j < N_HID; j++)
      for (int i = 0; i < N_IN; i++)
        mem[(RS1 >> 2) + 32'(j * N_IN + i)] = 32'(w1v(v, j, i));
    for (int k = 0; k < N_OUT; k++)
      for (int j = 0; j < N_HID; j++)
        mem[(RS1 >> 2) + 32'(N_IN * N_HID + k * N_HID + j)] = 32'(w2v(v, k, j));
    for (int i = 0; i < N_IN; i++)
      mem[(RS2 >> 2) + 32'(i)] = 32'(xv(v, i));
  endtask

  task automatic clear_counters();
    n_rd = 0; n_wr = 0; n_b2b = 0; n_oob = 0; n_wait_gap = 0;
  endtask

  task automatic start_insn();
    pcpi_insn  = NN_INSN;
    pcpi_rs1   = RS1;
    pcpi_rs2   = RS2;
    pcpi_valid = 1'b1;
  endtask

  // Memory model: answers each request with mem_ready exactly one cycle later.
  initial begin : mem_model
    logic [31:0] a;
    logic [31:0] rdata;
    wr_t e;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (resetn && mem_valid) begin
        a = mem_addr;
        rdata = '0;
        if (mem_write) begin
          n_wr++;
          mem[a >> 2] = mem_wdata;
          if (exp_wr.size() == 0) check("unexpected_write", 64'(mem_write), 64'd0);
          else begin
            e = exp_wr.pop_front();
            check("wr_addr", 64'(a), 64'(e.addr));
            check("wr_data", 64'(mem_wdata), 64'(e.data));
          end
        end else begin
          n_rd++;
          if (!((a >= RS1 && a < RS1 + 32'(4 * N_W)) || (a >= RS2 && a < RS2 + 32'(4 * N_IN))))
            n_oob++;
          rdata = mem.exists(a >> 2) ? mem[a >> 2] : 32'd0;
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  initial begin : b2b_monitor
    forever begin
      @(negedge clk);
      if (resetn && mem_valid && prev_mv) n_b2b++;
      prev_mv = mem_valid;
    end
  end

  initial begin : ready_monitor
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (pcpi_ready) begin
        if (exp_rd.size() == 0) check("unexpected_ready", 64'(pcpi_ready), 64'd0);
        else begin
          r = exp_rd.pop_front();
          check("rd", 64'(pcpi_rd), 64'(r));
          check("wr_with_ready", 64'(pcpi_wr), 64'd1);
          check("wait_at_ready", 64'(pcpi_wait), 64'd0);
        end
      end
    end
  end

  task automatic run_vec(input int v);
    wr_t e;
    logic got;
    load_vec(v);
    for (int k = 0; k < N_OUT; k++) begin
      e.addr = OUT_ADDR + 32'(4 * k);
      e.data = 32'(exp_y(v, k));
      exp_wr.push_back(e);
    end
    exp_rd.push_back(exp_class(v));
    clear_counters();
    @(negedge clk);
    start_insn();
    #1;
    if (!pcpi_wait) n_wait_gap++;
    got = 1'b0;
    for (int c = 0; c < RUN_BUDGET; c++) begin
      @(negedge clk);
      if (pcpi_ready) begin
        got = 1'b1;
        break;
      end
      if (!pcpi_wait) n_wait_gap++;
    end
    pcpi_valid = 1'b0;
    check($sformatf("v%0d_ready_seen", v), 64'(got), 64'd1);
    @(negedge clk);
    check($sformatf("v%0d_ready_one_cycle", v), 64'(pcpi_ready), 64'd0);
    check($sformatf("v%0d_rd_cleared", v), 64'(pcpi_rd), 64'd0);
    check($sformatf("v%0d_reads", v), 64'(n_rd), 64'(N_READS));
    check($sformatf("v%0d_writes", v), 64'(n_wr), 64'(N_OUT));
    check($sformatf("v%0d_back_to_back", v), 64'(n_b2b), 64'd0);
    check($sformatf("v%0d_addr_range", v), 64'(n_oob), 64'd0);
    check($sformatf("v%0d_wait_gaps", v), 64'(n_wait_gap), 64'd0);
    check($sformatf("v%0d_wr_left", v), 64'(exp_wr.size()), 64'd0);
    check($sformatf("v%0d_rd_left", v), 64'(exp_rd.size()), 64'd0);
    exp_wr.delete();
    exp_rd.delete();
  endtask

  task automatic foreign_insn(input string name, input logic [31:0] insn);
    int busy;
    busy = 0;
    @(negedge clk);
    pcpi_insn  = insn;
    pcpi_rs1   = RS1;
    pcpi_rs2   = RS2;
    pcpi_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (pcpi_wait || pcpi_ready || pcpi_wr || mem_valid) busy++;
    end
    pcpi_valid = 1'b0;
    check(name, 64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = '0;
    pcpi_rs1   = '0;
    pcpi_rs2   = '0;
    clear_counters();
    repeat (5) @(negedge clk);
    check("reset_outputs",
          64'({pcpi_wr, pcpi_wait, pcpi_ready, mem_valid, mem_write, pcpi_rd, mem_addr} != '0),
          64'd0);
    check("reset_wdata", 64'(mem_wdata), 64'd0);
    resetn = 1'b1;

    foreign_insn("foreign_mul_idle", MUL_INSN);
    foreign_insn("foreign_funct7_idle", NEAR_INSN);

    run_vec(0);
    run_vec(1);
    run_vec(2);
    run_vec(3);

    // Abort an inference mid layer 1; no ready and no logit writes may follow.
    load_vec(0);
    clear_counters();
    @(negedge clk);
    start_insn();
    repeat (300) @(negedge clk);
    check("midrun_busy", 64'(pcpi_wait), 64'd1);
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    @(negedge clk);
    check("midrun_reset_outputs",
          64'({pcpi_wr, pcpi_wait, pcpi_ready, mem_valid, mem_write, pcpi_rd, mem_addr} != '0),
          64'd0);
    check("midrun_reset_wdata", 64'(mem_wdata), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("midrun_no_writes", 64'(n_wr), 64'd0);

    run_vec(0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
